// File: rtl/store_req_unit.sv
// Store request unit: checks store alignment, builds byte strobes and lane-replicated data,
// and runs a req/addr_ok/data_ok write transaction to the data SRAM port.
module store_req_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_rt,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic              st_busy,
  output logic              st_done,
  output logic              ades,
  output logic [ADDR_W-1:0] ades_badvaddr
);

  localparam logic [2:0] OP_SB  = 3'd0;
  localparam logic [2:0] OP_SH  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_SWL = 3'd3;
  localparam logic [2:0] OP_SWR = 3'd4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              r_state;
  logic                r_flushed;
  logic                r_req;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ades;
  logic [ADDR_W-1:0]   r_badvaddr;

  logic [1:0]          w_off;
  logic [1:0]          w_size;
  logic [ADDR_W-1:0]   w_addr;
  logic [3:0]          w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_misal;
  logic                w_accept;

  assign w_off    = st_addr[1:0];
  assign st_ready = (r_state == IDLE);
  assign st_busy  = (r_state != IDLE);
  assign w_accept = st_valid & st_ready & ~flush & (st_op <= OP_SWR);

  // Request field construction from the incoming store
  always_comb begin
    w_size  = 2'd0;
    w_addr  = st_addr;
    w_wstrb = 4'b0000;
    w_wdata = st_rt;
    w_misal = 1'b0;
    case (st_op)
      OP_SB: begin
        w_wstrb = 4'b0001 << w_off;
        w_wdata = {4{st_rt[7:0]}};
      end
      OP_SH: begin
        w_size  = 2'd1;
        w_misal = w_off[0];
        w_wstrb = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_rt[15:0]}};
      end
      OP_SW: begin
        w_size  = 2'd2;
        w_misal = |w_off;
        w_wstrb = 4'b1111;
      end
      OP_SWL: begin
        w_size = 2'd2;
        w_addr = {st_addr[ADDR_W-1:2], 2'b00};
        case (w_off)
          2'd0: begin w_wstrb = 4'b0001; w_wdata = {24'b0, st_rt[31:24]}; end
          2'd1: begin w_wstrb = 4'b0011; w_wdata = {16'b0, st_rt[31:16]}; end
          2'd2: begin w_wstrb = 4'b0111; w_wdata = {8'b0, st_rt[31:8]}; end
          default: begin w_wstrb = 4'b1111; w_wdata = st_rt; end
        endcase
      end
      OP_SWR: begin
        w_size = 2'd2;
        w_addr = {st_addr[ADDR_W-1:2], 2'b00};
        case (w_off)
          2'd0: begin w_wstrb = 4'b1111; w_wdata = st_rt; end
          2'd1: begin w_wstrb = 4'b1110; w_wdata = {st_rt[23:0], 8'b0}; end
          2'd2: begin w_wstrb = 4'b1100; w_wdata = {st_rt[15:0], 16'b0}; end
          default: begin w_wstrb = 4'b1000; w_wdata = {st_rt[7:0], 24'b0}; end
        endcase
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_flushed  <= 1'b0;
      r_req      <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= '0;
      r_wstrb    <= 4'b0000;
      r_wdata    <= '0;
      r_ades     <= 1'b0;
      r_badvaddr <= '0;
    end else begin
      r_ades <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_misal) begin
            r_ades     <= 1'b1;
            r_badvaddr <= st_addr;
          end else if (w_accept) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
          end
        end
        REQ: begin
          // A write the SRAM has accepted must complete even if flushed
          if (data_addr_ok) begin
            r_state   <= WAIT;
            r_req     <= 1'b0;
            r_flushed <= flush;
          end else if (flush) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            r_state   <= IDLE;
            r_flushed <= 1'b0;
          end else if (flush) begin
            r_flushed <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_req      = r_req;
  assign data_wr       = r_req;
  assign data_size     = r_size;
  assign data_addr     = r_addr;
  assign data_wstrb    = r_wstrb;
  assign data_wdata    = r_wdata;
  assign ades          = r_ades;
  assign ades_badvaddr = r_badvaddr;
  assign st_done       = (r_state == WAIT) & data_data_ok & ~r_flushed & ~flush;

endmodule

// File: tb/tb_store_req_unit.sv
// Directed bench for store_req_unit: table of single stores plus hand sequences for
// stalls, flushes and reset in flight.
module tb_store_req_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_rt;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        st_busy;
  logic        st_done;
  logic        ades;
  logic [31:0] ades_badvaddr;

  int n_vec  = 0;
  int n_miss = 0;

  store_req_unit dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_rt(st_rt), .flush(flush), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .st_busy(st_busy), .st_done(st_done), .ades(ades),
    .ades_badvaddr(ades_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        eades;
    logic [1:0]  esize;
    logic [31:0] eaddr;
    logic [3:0]  estrb;
    logic [31:0] edata;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt);
    st_valid = 1'b1; st_op = op; st_addr = addr; st_rt = rt;
    tick();
    st_valid = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    issue(v.op, v.addr, v.rt);
    if (v.eades) begin
      check($sformatf("v%0d ades", i), {31'b0, ades}, 32'd1);
      check($sformatf("v%0d badvaddr", i), ades_badvaddr, v.addr);
      check($sformatf("v%0d no_req", i), {31'b0, data_req}, 32'd0);
      check($sformatf("v%0d ready", i), {31'b0, st_ready}, 32'd1);
      tick(); #1;
      check($sformatf("v%0d ades_pulse", i), {31'b0, ades}, 32'd0);
    end else begin
      check($sformatf("v%0d req", i), {30'b0, data_req, data_wr}, 32'd3);
      check($sformatf("v%0d size", i), {30'b0, data_size}, {30'b0, v.esize});
      check($sformatf("v%0d addr", i), data_addr, v.eaddr);
      check($sformatf("v%0d wstrb", i), {28'b0, data_wstrb}, {28'b0, v.estrb});
      check($sformatf("v%0d wdata", i), data_wdata, v.edata);
      check($sformatf("v%0d busy", i), {31'b0, st_busy}, 32'd1);
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1;
      #1;
      check($sformatf("v%0d req_drop", i), {31'b0, data_req}, 32'd0);
      check($sformatf("v%0d done", i), {31'b0, st_done}, 32'd1);
      tick();
      data_data_ok = 1'b0;
      #1;
      check($sformatf("v%0d done_pulse", i), {31'b0, st_done}, 32'd0);
      check($sformatf("v%0d idle", i), {30'b0, st_busy, st_ready}, 32'd1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req"}, {30'b0, data_req, data_wr}, 32'd0);
    check({tag, " size"}, {30'b0, data_size}, 32'd0);
    check({tag, " addr"}, data_addr, 32'd0);
    check({tag, " wstrb"}, {28'b0, data_wstrb}, 32'd0);
    check({tag, " wdata"}, data_wdata, 32'd0);
    check({tag, " ades"}, {31'b0, ades}, 32'd0);
    check({tag, " badvaddr"}, ades_badvaddr, 32'd0);
    check({tag, " ready_busy"}, {30'b0, st_ready, st_busy}, 32'd2);
  endtask

  initial begin
    vt[0]  = '{3'd0, 32'h8000_0003, 32'h1122_33A5, 1'b0, 2'd0, 32'h8000_0003, 4'b1000, 32'hA5A5_A5A5};
    vt[1]  = '{3'd0, 32'h8000_0000, 32'h0000_005A, 1'b0, 2'd0, 32'h8000_0000, 4'b0001, 32'h5A5A_5A5A};
    vt[2]  = '{3'd0, 32'h8000_0006, 32'h0000_0077, 1'b0, 2'd0, 32'h8000_0006, 4'b0100, 32'h7777_7777};
    vt[3]  = '{3'd3, 32'h0000_1001, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_1000, 4'b0011, 32'h0000_AABB};
    vt[4]  = '{3'd3, 32'h0000_1000, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_1000, 4'b0001, 32'h0000_00AA};
    vt[5]  = '{3'd3, 32'h0000_1002, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_1000, 4'b0111, 32'h00AA_BBCC};
    vt[6]  = '{3'd3, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_1000, 4'b1111, 32'hAABB_CCDD};
    vt[7]  = '{3'd4, 32'h0000_1002, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_1000, 4'b1100, 32'hCCDD_0000};
    vt[8]  = '{3'd4, 32'h0000_2001, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_2000, 4'b1110, 32'hBBCC_DD00};
    vt[9]  = '{3'd4, 32'h0000_2003, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_2000, 4'b1000, 32'hDD00_0000};
    vt[10] = '{3'd4, 32'h0000_2000, 32'hAABB_CCDD, 1'b0, 2'd2, 32'h0000_2000, 4'b1111, 32'hAABB_CCDD};
    vt[11] = '{3'd2, 32'h1000_0002, 32'hAABB_CCDD, 1'b1, 2'd0, 32'h0, 4'b0000, 32'h0};
    vt[12] = '{3'd1, 32'h1000_0001, 32'hAABB_CCDD, 1'b1, 2'd0, 32'h0, 4'b0000, 32'h0};
    vt[13] = '{3'd1, 32'h1000_0002, 32'hAABB_CCDD, 1'b0, 2'd1, 32'h1000_0002, 4'b1100, 32'hCCDD_CCDD};
    vt[14] = '{3'd1, 32'h1000_0000, 32'h1234_5678, 1'b0, 2'd1, 32'h1000_0000, 4'b0011, 32'h5678_5678};
    vt[15] = '{3'd2, 32'h1000_0004, 32'h1234_5678, 1'b0, 2'd2, 32'h1000_0004, 4'b1111, 32'h1234_5678};
    vt[16] = '{3'd2, 32'h1000_0001, 32'h1234_5678, 1'b1, 2'd0, 32'h0, 4'b0000, 32'h0};

    rst = 1'b1; st_valid = 1'b0; st_op = 3'd0; st_addr = 32'h0; st_rt = 32'h0;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_reset_vals("reset");
    check("reset stray_dok", {31'b0, st_done}, 32'd0);
    tick();
    data_data_ok = 1'b0;
    #1;
    check("reset stray_dok_idle", {30'b0, st_ready, data_req}, 32'd2);

    for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

    // Reserved op and valid-with-flush are not accepted
    issue(3'd5, 32'h0000_4000, 32'h1);
    check("rsvd noop", {29'b0, data_req, ades, st_ready}, 32'd1);
    flush = 1'b1;
    issue(3'd2, 32'h0000_4001, 32'h1);
    flush = 1'b0;
    #1;
    check("flush noaccept", {29'b0, data_req, ades, st_ready}, 32'd1);

    // Stall addr_ok for 5 cycles; stray data_ok in REQ is ignored
    issue(3'd2, 32'h0000_3000, 32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      data_data_ok = (c == 1);
      #1;
      check($sformatf("stall%0d req", c), {31'b0, data_req}, 32'd1);
      check($sformatf("stall%0d addr", c), data_addr, 32'h0000_3000);
      check($sformatf("stall%0d fields", c), {26'b0, data_size, data_wstrb}, {26'b0, 2'd2, 4'b1111});
      check($sformatf("stall%0d wdata", c), data_wdata, 32'hDEAD_BEEF);
      check($sformatf("stall%0d done", c), {31'b0, st_done}, 32'd0);
      tick();
    end
    data_data_ok = 1'b0;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    #1;
    check("stall done", {31'b0, st_done}, 32'd1);
    tick();
    data_data_ok = 1'b0;

    // Flush while REQ waits for addr_ok: request withdrawn
    issue(3'd0, 32'h0000_3001, 32'h0000_0011);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("withdraw req", {31'b0, data_req}, 32'd0);
    check("withdraw idle", {30'b0, st_ready, st_busy}, 32'd2);
    data_data_ok = 1'b1;
    #1;
    check("withdraw no_done", {31'b0, st_done}, 32'd0);
    tick();
    data_data_ok = 1'b0;

    // Flush coincident with addr_ok: write commits, no st_done
    issue(3'd0, 32'h0000_3002, 32'h0000_0022);
    data_addr_ok = 1'b1; flush = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("cflush%0d busy", c), {30'b0, st_busy, data_req}, 32'd2);
      check($sformatf("cflush%0d done", c), {31'b0, st_done}, 32'd0);
      tick();
    end
    data_data_ok = 1'b1;
    #1;
    check("cflush dok_done", {31'b0, st_done}, 32'd0);
    check("cflush dok_busy", {31'b0, st_busy}, 32'd1);
    tick();
    data_data_ok = 1'b0;
    #1;
    check("cflush ready", {31'b0, st_ready}, 32'd1);

    // Flush arriving during WAIT also suppresses st_done
    issue(3'd2, 32'h0000_3004, 32'h0000_0033);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; data_data_ok = 1'b1;
    #1;
    check("wflush done", {31'b0, st_done}, 32'd0);
    tick();
    data_data_ok = 1'b0;
    #1;
    check("wflush ready", {31'b0, st_ready}, 32'd1);

    // Reset while in WAIT, then a stray data_ok
    issue(3'd2, 32'h0000_5000, 32'h5555_AAAA);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; data_data_ok = 1'b1;
    #1;
    check_reset_vals("rstwait");
    check("rstwait done", {31'b0, st_done}, 32'd0);
    tick();
    data_data_ok = 1'b0;
    run_vec(99, vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/store_req_unit.md
Name: store_req_unit

Overview:
- Store-side counterpart of the load-data alignment stage.
- Accepts one store (SB/SH/SW/SWL/SWR) per handshake from the execute/memory-1 boundary.
- Checks alignment, then builds the little-endian byte strobes and the lane-replicated write data.
- Drives a request/addr_ok/data_ok data-SRAM-style write transaction, holds the pipeline busy until data_ok, and reports address errors (AdES) to CP0.

Parameters:
- ADDR_W, 32, address width; only 32 is supported.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. This is decided.
- st_valid  in  1  store request valid.
- st_ready  out  1  unit can accept a store (combinational, equals state==IDLE).
- st_op  in  3  0=SB, 1=SH, 2=SW, 3=SWL, 4=SWR; 5-7 are reserved and treated as no-op.
- st_addr  in  32  effective byte address.
- st_rt  in  32  rt register value.
- flush  in  1  pipeline flush (exception/eret).
- data_req  out  1  SRAM write request.
- data_wr  out  1  always 1 while data_req is high; otherwise 0.
- data_size  out  2  0=byte, 1=half, 2=word.
- data_addr  out  32  request address.
- data_wstrb  out  4  byte enables.
- data_wdata  out  32  write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  write completed.
- st_busy  out  1  stall to the pipeline: state != IDLE.
- st_done  out  1  one-cycle pulse: store completed and not flushed.
- ades  out  1  one-cycle pulse: misaligned store.
- ades_badvaddr  out  32  faulting address, valid while ades=1.

Behaviour:
- Reset: state=IDLE. data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0, ades=0, ades_badvaddr=0, flushed=0. An outstanding data_ok arriving after reset is ignored because IDLE ignores it.
- States are IDLE, REQ and WAIT.
- Accept condition: st_valid & st_ready & ~flush & op in 0..4.
- On accept with a misaligned address, no request is issued and the state stays IDLE. Next cycle ades=1 and ades_badvaddr=st_addr.
  - SH is misaligned when off[0]=1.
  - SW is misaligned when off!=0.
  - off = st_addr[1:0].
- On an aligned accept, all data_* registers are loaded and the state moves to REQ. data_req=1 from the next cycle.
- Field rules (all registered):
  - SB: size 0, addr=st_addr, wstrb=4'b0001<<off, wdata={4{rt[7:0]}}.
  - SH: size 1, addr=st_addr, wstrb= off0:0011, off2:1100; wdata={2{rt[15:0]}}.
  - SW: size 2, addr=st_addr, wstrb=1111, wdata=rt.
  - SWL: size 2, addr={st_addr[31:2],2'b00}.
    - off0: wstrb 0001, wdata {24'b0,rt[31:24]}.
    - off1: wstrb 0011, wdata {16'b0,rt[31:16]}.
    - off2: wstrb 0111, wdata {8'b0,rt[31:8]}.
    - off3: wstrb 1111, wdata rt.
  - SWR: size 2, word-aligned addr.
    - off0: wstrb 1111, wdata rt.
    - off1: wstrb 1110, wdata {rt[23:0],8'b0}.
    - off2: wstrb 1100, wdata {rt[15:0],16'b0}.
    - off3: wstrb 1000, wdata {rt[7:0],24'b0}.
- REQ state:
  - data_req stays high and all data_* fields stay stable until data_addr_ok.
  - On data_addr_ok, data_req drops the next cycle and the state moves to WAIT.
  - If flush=1 and data_addr_ok=0 in the same cycle, the request is withdrawn: next cycle data_req=0, state IDLE, no st_done.
  - If flush and addr_ok occur in the same cycle, the write is committed: go to WAIT with flushed=1.
- WAIT state:
  - A flush sets flushed=1 and the unit keeps waiting.
  - On data_data_ok the state returns to IDLE.
  - st_done = (state==WAIT) & data_data_ok & ~flushed & ~flush. It is combinational in the data_ok cycle.
  - flushed clears when the state returns to IDLE.
- data_data_ok in IDLE or REQ is ignored.
- Throughput: one store per at least 3 cycles. st_ready returns the cycle after data_ok.
- Latency: with addr_ok given in the first REQ cycle and data_ok the cycle after, the accept at cycle T gives data_req at T+1 and st_done at T+2.
- A reset mid-operation aborts immediately to IDLE with data_req=0.

Test Plan:
- SB, addr 0x8000_0003, rt 0x1122_33A5 → data_req next cycle with size 0, wstrb 1000, wdata 0xA5A5_A5A5. addr_ok same cycle, data_ok next cycle → st_done 1 pulse, st_busy low afterwards.
- SWL at 0x...01, rt 0xAABB_CCDD → addr 0x...00, wstrb 0011, wdata 0x0000_AABB. SWR at 0x...02 → wstrb 1100, wdata 0xCCDD_0000.
- SW at 0x1000_0002 → no data_req, ades=1 for one cycle, ades_badvaddr=0x1000_0002. SH at 0x...01 gives the same result; SH at 0x...02 → wstrb 1100, wdata 0xCCDD_CCDD.
- Hold addr_ok low for 5 cycles → data_req and all fields stable for 5 cycles. Assert flush in cycle 3 with addr_ok=0 → data_req drops, IDLE, no st_done.
- Flush coincident with addr_ok, then data_ok 4 cycles later → st_busy high throughout, st_done never pulses, st_ready high the next cycle.
- rst asserted while in WAIT, followed by a stray data_ok → all outputs return to reset values, no st_done. A new SB is accepted normally afterwards.
